row_weight_seq: RTL
===================

ROW_WEIGHT_SEQ -- requirements
Module: row_weight_seq

Interface
REQ-001 SHALL have parameter M, default 8, meaning weights per row.
REQ-002 SHALL have parameter S, default 8, meaning rows per pass.
REQ-003 SHALL have parameter n, default 32, meaning weight width in bits (Q16.16).
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port start, input, 1, a pulse that requests one pass over rows 0..S-1.
REQ-007 SHALL have port abort, input, 1, which cancels the pass in progress.
REQ-008 SHALL have port rom_addr, output, AW=$clog2(S), the row address to the combinational weight ROM.
REQ-009 SHALL have port rom_data, input, M*n, the ROM row for rom_addr, valid in the same cycle.
REQ-010 SHALL have port out_valid, output, 1, meaning an output row is presented.
REQ-011 SHALL have port out_ready, input, 1, the consumer's acceptance.
REQ-012 SHALL have port out_data, output, M*n, the registered weight row.
REQ-013 SHALL have port out_idx, output, AW, the row index of out_data.
REQ-014 SHALL have port out_last, output, 1, high when out_idx==S-1.
REQ-015 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-016 SHALL have port done, output, 1, a single-cycle pulse at the end of a pass.

Function
REQ-017 SHALL implement the states IDLE, RUN and DONE.
REQ-018 In IDLE, start SHALL load out_data<=rom_data with rom_addr=0, set out_idx=0 and out_valid=1 on the next cycle, and move to RUN.
REQ-019 In RUN, rom_addr SHALL equal out_idx+1 (saturating at S-1) so that the next row is prefetched combinationally.
REQ-020 A handshake (out_valid&&out_ready) with out_idx<S-1 SHALL load the next row and out_idx+1 on the following cycle, allowing one row per cycle at full throughput.
REQ-021 Without a handshake, out_data, out_idx and out_valid SHALL hold stable.
REQ-022 A handshake with out_idx==S-1 SHALL clear out_valid and enter DONE.
REQ-023 DONE SHALL assert done for exactly one cycle and then return to IDLE.
REQ-024 start in RUN or DONE SHALL be ignored, with no queuing.
REQ-025 abort in RUN SHALL clear out_valid on the next cycle and return to IDLE without a done pulse; abort SHALL take priority over a coincident handshake.
REQ-026 abort in IDLE or DONE SHALL have no effect.
REQ-027 In IDLE, rom_addr SHALL be 0.
REQ-028 With S=1, the first row SHALL have out_last=1 immediately.

Reset
REQ-029 rst SHALL force state IDLE, out_valid=0, out_data=0, out_idx=0, done=0 and busy=0 on the next edge.
REQ-030 rst SHALL override start and abort, including reset in the middle of a pass, which drops the row without a done pulse.

Configuration
REQ-031 Macro ROW_WEIGHT_SEQ_LOOP_EN SHALL, when defined, add input loop_en (1 bit) and output pass_cnt (16 bits).
REQ-032 With the macro defined and loop_en=1 at the last-row handshake, the block SHALL pulse done in the same cycle as the handshake, reload row 0 the next cycle and stay in RUN.
REQ-033 pass_cnt SHALL increment at every completed pass, wrap at 0xFFFF->0, and clear on rst.
REQ-034 Without the macro, neither port SHALL exist and behaviour SHALL be exactly REQ-017..REQ-028.

Structure
REQ-035 A shared package row_weight_pkg SHALL hold the state enum typedef (IDLE/RUN/DONE) and the default constants M, S and n.
REQ-036 The output register stage (data, idx, valid, last) SHALL be a sub-module rws_out_stage; the FSM and counter SHALL stay in the top level.

Verification
REQ-037 The bench SHALL cover: reset, start, out_ready=1 constantly -> rows 0..7 on 8 consecutive cycles, out_last on row 7, done one cycle after the row-7 handshake, busy low the cycle after.
REQ-038 The bench SHALL cover: out_ready toggling 1,0,0,1,... -> out_data/out_idx held while out_ready=0, no row skipped or repeated, and out_idx==2 row data equal to the ROM row 2 contents.
REQ-039 The bench SHALL cover: abort when out_idx==3 together with out_ready=1 -> out_valid=0 next cycle, state IDLE, no done pulse; a subsequent start restarts at row 0.
REQ-040 The bench SHALL cover: start pulsed while busy at idx 5 -> ignored, pass ends normally with a single done.
REQ-041 The bench SHALL cover: rst asserted in the middle of a pass at idx 4 -> all outputs zero next cycle, and a following start yields row 0.
REQ-042 With ROW_WEIGHT_SEQ_LOOP_EN defined, the bench SHALL cover: loop_en=1 for 3 passes -> 24 consecutive rows with idx wrapping 7->0, three done pulses, pass_cnt=3.

Source files
------------

// File: rtl/row_weight_pkg.sv
// Shared types and default sizing for the row weight sequencer.
package row_weight_pkg;

    // Default weights per row, rows per pass and weight width (Q16.16).
    localparam int DEF_M = 8;
    localparam int DEF_S = 8;
    localparam int DEF_N = 32;

    // Sequencer control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/rws_out_stage.sv
// Output register stage of the row weight sequencer: holds the presented
// row, its index, the valid flag and the last-row flag. A load captures a
// new row and raises valid; a clear drops valid; otherwise everything holds.
module rws_out_stage #(
    parameter int M  = 8,
    parameter int S  = 8,
    parameter int n  = 32,
    parameter int AW = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             clear,
    input  logic [M*n-1:0]   load_data,
    input  logic [AW-1:0]    load_idx,
    output logic [M*n-1:0]   out_data,
    output logic [AW-1:0]    out_idx,
    output logic             out_valid,
    output logic             out_last
);

    logic [M*n-1:0] data_q, data_d;
    logic [AW-1:0]  idx_q, idx_d;
    logic           valid_q, valid_d;
    logic           last_q, last_d;

    // Next-state: load wins over clear, otherwise hold the presented row.
    always_comb begin
        data_d  = data_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        last_d  = last_q;
        if (load) begin
            data_d  = load_data;
            idx_d   = load_idx;
            valid_d = 1'b1;
            last_d  = (load_idx == AW'(S - 1));
        end else if (clear) begin
            valid_d = 1'b0;
        end
    end

    // Output registers; last tracks idx==S-1, so it is set out of reset when S==1.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= (S == 1);
        end else begin
            data_q  <= data_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign out_data  = data_q;
    assign out_idx   = idx_q;
    assign out_valid = valid_q;
    assign out_last  = last_q;

endmodule

// File: rtl/row_weight_seq.sv
// Row weight sequencer: on start, streams rows 0..S-1 of a combinational
// weight ROM to a valid/ready consumer, prefetching the next row so a row
// can be accepted every cycle. abort cancels a pass, done pulses at its end.
// Optional macro ROW_WEIGHT_SEQ_LOOP_EN adds loop_en (restart at row 0 after
// the last row without leaving RUN) and a 16-bit completed-pass counter.
module row_weight_seq
    import row_weight_pkg::*;
#(
    parameter int M = DEF_M,
    parameter int S = DEF_S,
    parameter int n = DEF_N,
    localparam int AW = (S > 1) ? $clog2(S) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic [AW-1:0]    rom_addr,
    input  logic [M*n-1:0]   rom_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [M*n-1:0]   out_data,
    output logic [AW-1:0]    out_idx,
    output logic             out_last,
    output logic             busy,
    output logic             done
`ifdef ROW_WEIGHT_SEQ_LOOP_EN
    ,
    input  logic             loop_en,
    output logic [15:0]      pass_cnt
`endif
);

    state_t        state_q, state_d;
    logic          load;
    logic          clear;
    logic [AW-1:0] load_idx;
    logic [AW-1:0] next_idx;
    logic          at_last;
    logic          hs;

`ifdef ROW_WEIGHT_SEQ_LOOP_EN
    logic [15:0]   pass_cnt_q, pass_cnt_d;
`endif

    assign hs      = out_valid && out_ready;
    assign at_last = (out_idx == AW'(S - 1));

    // FSM next-state, ROM address, output-stage control and done pulse.
    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        clear    = 1'b0;
        load_idx = '0;
        next_idx = out_idx + AW'(1);
        rom_addr = '0;
        done     = 1'b0;
`ifdef ROW_WEIGHT_SEQ_LOOP_EN
        pass_cnt_d = pass_cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                // ROM address 0 here, so rom_data already carries row 0.
                if (start) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Prefetch the following row; hold at the last row.
                rom_addr = at_last ? AW'(S - 1) : next_idx;
`ifdef ROW_WEIGHT_SEQ_LOOP_EN
                if (at_last && loop_en) begin
                    rom_addr = '0;
                end
`endif
                if (abort) begin
                    clear   = 1'b1;
                    state_d = IDLE;
                end else if (hs) begin
                    if (!at_last) begin
                        load     = 1'b1;
                        load_idx = next_idx;
                    end else begin
`ifdef ROW_WEIGHT_SEQ_LOOP_EN
                        pass_cnt_d = pass_cnt_q + 16'd1;
                        if (loop_en) begin
                            load = 1'b1;
                            done = 1'b1;
                        end else begin
                            clear   = 1'b1;
                            state_d = DONE;
                        end
`else
                        clear   = 1'b1;
                        state_d = DONE;
`endif
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef ROW_WEIGHT_SEQ_LOOP_EN
    // Completed-pass counter, wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            pass_cnt_q <= '0;
        end else begin
            pass_cnt_q <= pass_cnt_d;
        end
    end

    assign pass_cnt = pass_cnt_q;
`endif

    assign busy = (state_q != IDLE);

    rws_out_stage #(
        .M  (M),
        .S  (S),
        .n  (n),
        .AW (AW)
    ) u_out_stage (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .clear     (clear),
        .load_data (rom_data),
        .load_idx  (load_idx),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_valid (out_valid),
        .out_last  (out_last)
    );

endmodule
